// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release (PLL -> core -> peripherals) gated on a
// synchronised PLL lock, with lock timeout/retry, lock-loss and software replay.
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned STAGE_GAP    = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       sw_reset_req,
  output logic       pll_reset,
  output logic       core_reset_n,
  output logic       periph_reset_n,
  output logic       seq_done,
  output logic       lock_timeout,
  output logic       lock_lost,
  output logic [1:0] seq_state
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_LOCK = 2'd1,
    S_CORE = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  // Terminal counter values: a stage lasting N edges ends when the count is N-1
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta;
  logic             lock_s;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Sequencer FSM with registered reset outputs and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_HOLD;
      cnt            <= '0;
      pll_reset      <= 1'b1;
      core_reset_n   <= 1'b0;
      periph_reset_n <= 1'b0;
      seq_done       <= 1'b0;
      lock_timeout   <= 1'b0;
      lock_lost      <= 1'b0;
    end else if (sw_reset_req) begin
      // Software request wins over everything and leaves the flags alone
      state          <= S_HOLD;
      cnt            <= '0;
      pll_reset      <= 1'b1;
      core_reset_n   <= 1'b0;
      periph_reset_n <= 1'b0;
      seq_done       <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state     <= S_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_LOCK: begin
          if (lock_s) begin
            state        <= S_CORE;
            cnt          <= '0;
            core_reset_n <= 1'b1;
          end else if (cnt == TO_LAST) begin
            state        <= S_HOLD;
            cnt          <= '0;
            pll_reset    <= 1'b1;
            lock_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CORE: begin
          if (!lock_s) begin
            state          <= S_HOLD;
            cnt            <= '0;
            pll_reset      <= 1'b1;
            core_reset_n   <= 1'b0;
            periph_reset_n <= 1'b0;
            seq_done       <= 1'b0;
            lock_lost      <= 1'b1;
          end else if (cnt == GAP_LAST) begin
            state          <= S_RUN;
            cnt            <= '0;
            periph_reset_n <= 1'b1;
            seq_done       <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state          <= S_HOLD;
            cnt            <= '0;
            pll_reset      <= 1'b1;
            core_reset_n   <= 1'b0;
            periph_reset_n <= 1'b0;
            seq_done       <= 1'b0;
            lock_lost      <= 1'b1;
          end
        end
      endcase
    end
  end

  assign seq_state = 2'(state);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD_CYCLES=4, STAGE_GAP=3, LOCK_TIMEOUT=10.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       sw_reset_req;
  logic       pll_reset;
  logic       core_reset_n;
  logic       periph_reset_n;
  logic       seq_done;
  logic       lock_timeout;
  logic       lock_lost;
  logic [1:0] seq_state;

  int errors = 0;
  int checks = 0;

  reset_sequencer #(
    .HOLD_CYCLES (4),
    .STAGE_GAP   (3),
    .LOCK_TIMEOUT(10),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .sw_reset_req  (sw_reset_req),
    .pll_reset     (pll_reset),
    .core_reset_n  (core_reset_n),
    .periph_reset_n(periph_reset_n),
    .seq_done      (seq_done),
    .lock_timeout  (lock_timeout),
    .lock_lost     (lock_lost),
    .seq_state     (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {pll_reset, core_reset_n, periph_reset_n, seq_done, lock_timeout, lock_lost, seq_state}
  task automatic expect_out(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pll_reset, core_reset_n, periph_reset_n, seq_done,
           lock_timeout, lock_lost, seq_state};
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  // Advance n rising edges, then settle 1ns past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop rst just after an edge so the next rising edge is edge 1
  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    pll_lock     = 1'b0;
    sw_reset_req = 1'b0;
    #3;
    expect_out("reset_values", 8'b1000_0000);

    // Lock held low: timeout and retry, then lock completes the sequence
    release_rst();
    step(3);  expect_out("t2_hold_e3",     8'b1000_0000);
    step(1);  expect_out("t2_lock_e4",     8'b0000_0001);
    step(9);  expect_out("t2_lock_e13",    8'b0000_0001);
    step(1);  expect_out("t2_timeout_e14", 8'b1000_1000);
    step(3);  expect_out("t2_hold_e17",    8'b1000_1000);
    step(1);  expect_out("t2_lock_e18",    8'b0000_1001);
    pll_lock = 1'b1;
    step(2);  expect_out("t2_lock_e20",    8'b0000_1001);
    step(1);  expect_out("t2_core_e21",    8'b0100_1010);
    step(2);  expect_out("t2_core_e23",    8'b0100_1010);
    step(1);  expect_out("t2_run_e24",     8'b0111_1011);

    // One-cycle lock drop in RUN: resets reassert on the 3rd edge
    pll_lock = 1'b0;
    step(1);  expect_out("t3_drop_e1",     8'b0111_1011);
    pll_lock = 1'b1;
    step(1);  expect_out("t3_drop_e2",     8'b0111_1011);
    step(1);  expect_out("t3_lost_e3",     8'b1000_1100);
    step(3);  expect_out("t3_hold",        8'b1000_1100);
    step(1);  expect_out("t3_relock",      8'b0000_1101);
    step(1);  expect_out("t3_core",        8'b0100_1110);
    step(2);  expect_out("t3_core_last",   8'b0100_1110);
    step(1);  expect_out("t3_run",         8'b0111_1111);

    // Software reset pulse in RUN
    sw_reset_req = 1'b1;
    step(1);  expect_out("t4_sw_hold",     8'b1000_1100);
    sw_reset_req = 1'b0;
    step(3);  expect_out("t4_hold",        8'b1000_1100);
    step(1);  expect_out("t4_lock",        8'b0000_1101);
    step(1);  expect_out("t4_core",        8'b0100_1110);
    step(1);  expect_out("t4_core2",       8'b0100_1110);

    // Asynchronous rst mid-CORE clears everything before the next edge
    #2;
    rst = 1'b1;
    #1;       expect_out("t6_async_rst",   8'b1000_0000);

    // Nominal sequence with lock tied high
    release_rst();
    step(3);  expect_out("t1_hold_e3",     8'b1000_0000);
    step(1);  expect_out("t1_lock_e4",     8'b0000_0001);
    step(1);  expect_out("t1_core_e5",     8'b0100_0010);
    step(2);  expect_out("t1_core_e7",     8'b0100_0010);
    step(1);  expect_out("t1_run_e8",      8'b0111_0011);

    // Software request on the timeout edge suppresses the timeout flag
    rst      = 1'b1;
    pll_lock = 1'b0;
    #1;       expect_out("t5_reset",       8'b1000_0000);
    release_rst();
    step(13); expect_out("t5_lock_e13",    8'b0000_0001);
    sw_reset_req = 1'b1;
    step(1);  expect_out("t5_sw_e14",      8'b1000_0000);
    sw_reset_req = 1'b0;
    step(4);  expect_out("t5_lock_e18",    8'b0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
